// File: rtl/com_to_fifo_pkg.sv
// Shared definitions for the UART receive stage that feeds the FIFO.
// Holds receiver state encodings, frame width and the error-counter helper.
package com_to_fifo_pkg;

   localparam int UART_DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rxState_t;

   function automatic logic [3:0] satInc(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

endpackage

// File: rtl/com_to_fifo_if.sv
// Write-side handshake between the UART receive stage and the FIFO.
// The receive stage is the master; the FIFO is the slave.
interface com_to_fifo_if;
   import com_to_fifo_pkg::*;

   logic [UART_DATA_BITS-1:0] fifo_data;
   logic                      fifo_we;
   logic                      fifo_busy;
   logic                      fifo_full;

   modport master (output fifo_data, output fifo_we, input fifo_busy, input fifo_full);
   modport slave  (input fifo_data, input fifo_we, output fifo_busy, output fifo_full);

endinterface

// File: rtl/com_to_fifo_uart_rx_core.sv
// UART receiver: two-flop rx synchroniser plus frame FSM with parity/stop checks.
// Emits one-cycle byteValid / parityErr / frameErr pulses on the stop-sample cycle.
//
// state  | meaning
// IDLE   | line idle, waiting for rx_s low while enabled
// START  | half-bit wait, then confirm start bit (high = glitch)
// DATA   | sample 8 data bits LSB first, one per OVERSAMPLE cycles
// PARITY | sample parity bit, latch mismatch
// STOP   | sample stop bit, report result, return to IDLE
module uart_rx_core
   import com_to_fifo_pkg::*;
#(
   parameter int OVERSAMPLE = 16,
   parameter bit PARITY_EN  = 1'b1,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic                      rx,
   output logic [UART_DATA_BITS-1:0] rxByte,
   output logic                      byteValid,
   output logic                      parityErr,
   output logic                      frameErr,
   output logic                      rxActive
);

   localparam int            CW        = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(OVERSAMPLE - 1);
   localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);

   rxState_t                  state;
   logic                      rxMeta;
   logic                      rxS;
   logic [CW-1:0]             tickCnt;
   logic [2:0]                bitIdx;
   logic [UART_DATA_BITS-1:0] shiftReg;
   logic                      badParity;
   logic                      bitTick;

   assign bitTick = (tickCnt == BIT_LAST);

   always_ff @(posedge clk) begin
      if (!reset) begin
         rxMeta    <= 1'b1;
         rxS       <= 1'b1;
         state     <= IDLE;
         tickCnt   <= '0;
         bitIdx    <= '0;
         shiftReg  <= '0;
         badParity <= 1'b0;
         rxByte    <= '0;
         byteValid <= 1'b0;
         parityErr <= 1'b0;
         frameErr  <= 1'b0;
         rxActive  <= 1'b0;
      end else begin
         rxMeta    <= rx;
         rxS       <= rxMeta;
         byteValid <= 1'b0;
         parityErr <= 1'b0;
         frameErr  <= 1'b0;
         case (state)
            IDLE: begin
               if (enable && !rxS) begin
                  state    <= START;
                  tickCnt  <= '0;
                  rxActive <= 1'b1;
               end
            end
            START: begin
               if (tickCnt == HALF_LAST) begin
                  tickCnt <= '0;
                  if (rxS) begin
                     state    <= IDLE;
                     rxActive <= 1'b0;
                  end else begin
                     state     <= DATA;
                     bitIdx    <= '0;
                     badParity <= 1'b0;
                  end
               end else begin
                  tickCnt <= tickCnt + 1'b1;
               end
            end
            DATA: begin
               if (bitTick) begin
                  tickCnt  <= '0;
                  shiftReg <= {rxS, shiftReg[UART_DATA_BITS-1:1]};
                  bitIdx   <= bitIdx + 1'b1;
                  if (bitIdx == LAST_BIT) begin
                     if (PARITY_EN) state <= PARITY;
                     else           state <= STOP;
                  end
               end else begin
                  tickCnt <= tickCnt + 1'b1;
               end
            end
            PARITY: begin
               if (bitTick) begin
                  tickCnt   <= '0;
                  badParity <= (rxS != ((^shiftReg) ^ PARITY_ODD));
                  state     <= STOP;
               end else begin
                  tickCnt <= tickCnt + 1'b1;
               end
            end
            STOP: begin
               if (bitTick) begin
                  tickCnt  <= '0;
                  state    <= IDLE;
                  rxActive <= 1'b0;
                  // A bad stop bit masks a parity fault in the same frame.
                  if (!rxS) begin
                     frameErr <= 1'b1;
                  end else if (badParity) begin
                     parityErr <= 1'b1;
                  end else begin
                     byteValid <= 1'b1;
                     rxByte    <= shiftReg;
                  end
               end else begin
                  tickCnt <= tickCnt + 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               rxActive <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/com_to_fifo.sv
// UART receive stage: wraps uart_rx_core with a one-byte hold register,
// the FIFO busy/full write handshake, a sticky overflow flag and an error counter.
module com_to_fifo
   import com_to_fifo_pkg::*;
#(
   parameter int OVERSAMPLE = 16,
   parameter bit PARITY_EN  = 1'b1,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 rx,
   com_to_fifo_if.master        fifo,
   output logic                 rx_active,
   output logic                 parity_error,
   output logic                 frame_error,
   output logic                 overflow,
   output logic [3:0]           err_count
);

   logic [UART_DATA_BITS-1:0] rxByte;
   logic [UART_DATA_BITS-1:0] holdData;
   logic                      byteValid;
   logic                      holdFull;
   logic                      canPush;

   uart_rx_core #(
      .OVERSAMPLE (OVERSAMPLE),
      .PARITY_EN  (PARITY_EN),
      .PARITY_ODD (PARITY_ODD)
   ) u_rx (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .rx        (rx),
      .rxByte    (rxByte),
      .byteValid (byteValid),
      .parityErr (parity_error),
      .frameErr  (frame_error),
      .rxActive  (rx_active)
   );

   assign canPush = !fifo.fifo_busy && !fifo.fifo_full;

   always_ff @(posedge clk) begin
      if (!reset) begin
         holdFull       <= 1'b0;
         holdData       <= '0;
         fifo.fifo_we   <= 1'b0;
         fifo.fifo_data <= '0;
         overflow       <= 1'b0;
         err_count      <= '0;
      end else begin
         fifo.fifo_we <= 1'b0;
         if (parity_error || frame_error) err_count <= satInc(err_count);
         if (holdFull) begin
            // Draining the held byte frees the slot for a byte arriving now.
            if (canPush) begin
               fifo.fifo_we   <= 1'b1;
               fifo.fifo_data <= holdData;
               holdFull       <= byteValid;
               holdData       <= rxByte;
            end else if (byteValid) begin
               overflow <= 1'b1;
            end
         end else if (byteValid) begin
            if (canPush) begin
               fifo.fifo_we   <= 1'b1;
               fifo.fifo_data <= rxByte;
            end else begin
               holdFull <= 1'b1;
               holdData <= rxByte;
            end
         end
      end
   end

endmodule
